// File: rtl/lm75_poller.sv
// LM75 temperature poller: configures the sensor once, then reads it periodically via an I2C master.
// Define LM75_POLL_ALARM_EN to build the signed high/low hysteresis alarm; otherwise Alarm is tied low.
module lm75_poller #(
  parameter logic        [6:0] SLAVE_ADR  = 7'b1001101,
  parameter logic        [7:0] CFG_BYTE   = 8'h00,
  parameter int unsigned       POLL_TICKS = 50000,
  parameter int unsigned       MAX_RETRY  = 3,
  parameter logic signed [7:0] T_HIGH     = 8'sh50,
  parameter logic signed [7:0] T_LOW      = 8'sh4B
) (
  input  logic       Clk_in,
  input  logic       Rst,
  input  logic       En,
  input  logic       Clr_fault,
  output logic       M_Start,
  output logic [6:0] M_Adr,
  output logic [7:0] M_Pointer,
  output logic       M_R_W,
  output logic [7:0] M_Data_in,
  output logic [7:0] M_Data_in2,
  input  logic       M_Ready,
  input  logic       M_Error,
  input  logic [7:0] M_Data_out,
  output logic [7:0] Temp,
  output logic       Temp_valid,
  output logic       Fault,
  output logic       Alarm,
  output logic [7:0] Err_count
);

  localparam int TICK_W  = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(POLL_TICKS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE, CFG_ISSUE, CFG_BUSY, CFG_DONE,
    RD_ISSUE, RD_BUSY, RD_DONE, INTERVAL, FAULT
  } state_e;

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [7:0]           err_q, err_d;
  logic [7:0]           temp_q, temp_d;
  logic                 tv_q, tv_d;

  logic [RETRY_W-1:0]   retryInc;
  logic                 retryHit;
  logic [7:0]           errInc;

  assign retryInc = retry_q + 1'b1;
  assign retryHit = (retryInc >= RETRY_MAX);
  assign errInc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      retry_q <= '0;
      err_q   <= '0;
      temp_q  <= '0;
      tv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      temp_q  <= temp_d;
      tv_q    <= tv_d;
    end
  end

  // A failed transaction (M_Error seen with M_Ready) retries until MAX_RETRY in a row, then faults.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    retry_d = retry_q;
    err_d   = err_q;
    temp_d  = temp_q;
    tv_d    = 1'b0;
    case (state_q)
      IDLE:      if (En && M_Ready) state_d = CFG_ISSUE;
      CFG_ISSUE: state_d = CFG_BUSY;
      CFG_BUSY:  if (!M_Ready) state_d = CFG_DONE;
      CFG_DONE: begin
        if (M_Ready) begin
          if (M_Error) begin
            err_d   = errInc;
            retry_d = retryInc;
            if (retryHit)  state_d = FAULT;
            else if (!En)  state_d = IDLE;
            else           state_d = CFG_ISSUE;
          end else begin
            retry_d = '0;
            state_d = En ? RD_ISSUE : IDLE;
          end
        end
      end
      RD_ISSUE:  state_d = RD_BUSY;
      RD_BUSY:   if (!M_Ready) state_d = RD_DONE;
      RD_DONE: begin
        if (M_Ready) begin
          if (M_Error) begin
            err_d   = errInc;
            retry_d = retryInc;
            if (retryHit)  state_d = FAULT;
            else if (!En)  state_d = IDLE;
            else           state_d = RD_ISSUE;
          end else begin
            temp_d  = M_Data_out;
            tv_d    = 1'b1;
            retry_d = '0;
            tick_d  = '0;
            state_d = En ? INTERVAL : IDLE;
          end
        end
      end
      INTERVAL: begin
        if (tick_q == TICK_LAST) state_d = En ? RD_ISSUE : IDLE;
        else                     tick_d  = tick_q + 1'b1;
      end
      FAULT: begin
        if (Clr_fault) begin
          retry_d = '0;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    M_Start    = 1'b0;
    M_Adr      = '0;
    M_Pointer  = '0;
    M_R_W      = 1'b0;
    M_Data_in  = '0;
    M_Data_in2 = '0;
    case (state_q)
      CFG_ISSUE, CFG_BUSY, CFG_DONE: begin
        M_Start   = (state_q == CFG_ISSUE);
        M_Adr     = SLAVE_ADR;
        M_Pointer = 8'h01;
        M_Data_in = CFG_BYTE;
      end
      RD_ISSUE, RD_BUSY, RD_DONE: begin
        M_Start   = (state_q == RD_ISSUE);
        M_Adr     = SLAVE_ADR;
        M_Pointer = 8'h00;
        M_R_W     = 1'b1;
      end
      default: ;
    endcase
  end

  assign Temp       = temp_q;
  assign Temp_valid = tv_q;
  assign Fault      = (state_q == FAULT);
  assign Err_count  = err_q;

`ifdef LM75_POLL_ALARM_EN
  logic alarm_q;

  // Hysteresis: only a fresh reading can move the alarm, and the band between thresholds holds it.
  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      alarm_q <= 1'b0;
    end else if (tv_d) begin
      if ($signed(temp_d) >= T_HIGH)    alarm_q <= 1'b1;
      else if ($signed(temp_d) < T_LOW) alarm_q <= 1'b0;
    end
  end

  assign Alarm = alarm_q;
`else
  assign Alarm = 1'b0;
`endif

endmodule

// File: doc/lm75_poller.md
LM75_POLLER -- requirements
Module: lm75_poller

Interface
REQ-001 Parameter SLAVE_ADR, default 7'b1001101: 7-bit I2C address of the LM75x target.
REQ-002 Parameter CFG_BYTE, default 8'h00: value written to the LM75 config register (pointer 8'h01) at start-up.
REQ-003 Parameter POLL_TICKS, default 50000: Clk_in cycles between end of one read and start of the next (1 ms at 50 MHz).
REQ-004 Parameter MAX_RETRY, default 3: consecutive failed transactions tolerated before Fault.
REQ-005 Parameters T_HIGH (8'h50) and T_LOW (8'h4B): signed alarm set and clear thresholds, in integer degrees C.
REQ-006 Clk_in  in  1  single system clock; all logic is rising-edge.
REQ-007 Rst  in  1  synchronous, active-low reset.
REQ-008 En  in  1  polling enable; level-sensitive.
REQ-009 Clr_fault  in  1  one-cycle pulse that leaves FAULT.
REQ-010 M_Start  out  1  one-cycle transaction request to Master.
REQ-011 M_Adr  out  7 , M_Pointer  out  8 , M_R_W  out  1 , M_Data_in  out  8 , M_Data_in2  out  8  Master command fields.
REQ-012 M_Ready  in  1 , M_Error  in  1 , M_Data_out  in  8  Master status and read byte.
REQ-013 Temp  out  8  last good temperature MSB (two's complement, degrees C).
REQ-014 Temp_valid  out  1  one-cycle pulse when Temp updates.
REQ-015 Fault  out  1 , Alarm  out  1 , Err_count  out  8  status outputs.

Function
REQ-016 States: IDLE, CFG_ISSUE, CFG_BUSY, CFG_DONE, RD_ISSUE, RD_BUSY, RD_DONE, INTERVAL, FAULT.
REQ-017 IDLE: if En=1 and M_Ready=1, go to CFG_ISSUE; otherwise remain in IDLE.
REQ-018 CFG_ISSUE: drive M_Start=1 for exactly one cycle with M_Adr=SLAVE_ADR, M_Pointer=8'h01, M_R_W=0, M_Data_in=CFG_BYTE, M_Data_in2=8'h00, then go to CFG_BUSY.
REQ-019 Command fields stay stable from the ISSUE cycle until the matching DONE state exits.
REQ-020 BUSY states wait for M_Ready=0, then go to the matching DONE state.
REQ-021 DONE states wait for M_Ready=1 and sample M_Error and M_Data_out in that same cycle.
REQ-022 CFG_DONE: if M_Error=0, go to RD_ISSUE; if M_Error=1, retry from CFG_ISSUE.
REQ-023 RD_ISSUE: issue M_Adr=SLAVE_ADR, M_Pointer=8'h00, M_R_W=1.
REQ-024 RD_DONE with M_Error=0: Temp<=M_Data_out, Temp_valid=1 for one cycle, retry counter cleared, go to INTERVAL.
REQ-025 RD_DONE with M_Error=1: Temp held, Err_count+1, retry counter+1, reissue RD_ISSUE.
REQ-026 Err_count saturates at 8'hFF.
REQ-027 When the retry counter reaches MAX_RETRY, go to FAULT and set Fault=1; no M_Start is issued while in FAULT.
REQ-028 Clr_fault in FAULT clears Fault and the retry counter, then goes to IDLE, which reruns configuration; Err_count is kept.
REQ-029 INTERVAL counts POLL_TICKS cycles.
REQ-030 At the end of INTERVAL: if En=1, go to RD_ISSUE; if En=0, go to IDLE.
REQ-031 En=0 mid-transaction: the current transaction completes normally, then the block goes to IDLE; transactions are never aborted.
REQ-032 If M_Error and M_Ready rise in the same cycle, the transaction counts as a failure.

Reset
REQ-033 Rst=0 at a rising edge sets state IDLE and clears the counters.
REQ-034 Reset values: M_Start=0, M_R_W=0, all M_ fields 0, Temp=8'h00, Temp_valid=0, Fault=0, Alarm=0, Err_count=0.
REQ-035 Reset mid-transaction drops M_Start the next cycle; the block then waits in IDLE for M_Ready=1 before any new command.

Configuration
REQ-036 Macro LM75_POLL_ALARM_EN defined: on each Temp_valid, Alarm is set when signed Temp>=T_HIGH and cleared when signed Temp<T_LOW; Alarm otherwise holds (hysteresis).
REQ-037 Macro LM75_POLL_ALARM_EN undefined: Alarm is tied to 0, no comparator logic exists, and the port list is unchanged.

Verification
REQ-038 Reset, then En=1 with Master model idle -> one M_Start with Adr=1001101, Pointer=01, R_W=0, Data_in=00; then a read with Pointer=00, R_W=1.
REQ-039 LM75 model returns 0x19 -> Temp=0x19 with a single Temp_valid pulse; the next M_Start comes POLL_TICKS cycles after RD_DONE exits.
REQ-040 Forced M_Error on 3 consecutive reads -> Err_count=3, Fault=1, no further M_Start; Clr_fault -> configuration write is reissued.
REQ-041 ALARM_EN defined, reads of 0x50, 0x4C, 0x4A -> Alarm 1, 1, 0; repeat with macro undefined -> Alarm stays 0.
REQ-042 En dropped during RD_BUSY -> Temp_valid still pulses, then state is IDLE with no further M_Start.
REQ-043 Rst=0 during CFG_BUSY -> all outputs at reset values on the next edge; after release, no M_Start until M_Ready=1.
